// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared constants for the LSTM backprop blocks
package lstm_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int Q_WIDTH = 32;
    localparam logic [Q_WIDTH-1:0] ONE_Q = 32'h01000000;
    localparam logic [Q_WIDTH-1:0] ZERO  = {Q_WIDTH{1'b0}};
endpackage

// File: rtl/grad_acc_if.sv
// rtl/grad_acc_if.sv - delta handshake and operand-memory read port of grad_acc
interface grad_acc_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] i_dgate;
    logic             i_valid;
    logic             o_ready;
    logic             o_rd_en;
    logic [AW-1:0]    o_rd_addr;
    logic [WIDTH-1:0] i_x;

    // master: delta stage plus operand memory; slave: the accumulator
    modport master (output i_dgate, i_valid, i_x, input o_ready, o_rd_en, o_rd_addr);
    modport slave  (input i_dgate, i_valid, i_x, output o_ready, o_rd_en, o_rd_addr);
endinterface

// File: rtl/grad_acc_mult.sv
// rtl/grad_acc_mult.sv - mult_2in: fixed-point multiply, full product shifted right by FRAC
module mult_2in #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);
    logic signed [2*WIDTH-1:0] prod;

    assign prod = a * b;
    assign y    = WIDTH'(prod >>> FRAC);
endmodule

// File: rtl/grad_acc.sv
// rtl/grad_acc.sv - per-gate weight/bias gradient accumulator (acc[i] += d*x[i], acc[NIN] += d)
module grad_acc
    import lstm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int NIN   = 4,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    grad_acc_if.slave        bus,
    input  logic             i_clr,
    input  logic [AW-1:0]    i_rd_idx,
    output logic [WIDTH-1:0] o_grad,
    output logic             o_done,
    output logic [15:0]      o_count
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             av_q, av_d;
    logic [WIDTH-1:0] acc_q [0:NIN];
    logic [WIDTH-1:0] acc_d [0:NIN];
    logic [WIDTH-1:0] grad_q, grad_d;
    logic [15:0]      count_q, count_d;
    logic [WIDTH-1:0] prod;

    mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mult (
        .a (d_q),
        .b (bus.i_x),
        .y (prod)
    );

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        addr_d  = cnt_q;
        av_d    = 1'b0;
        count_d = count_q;
        acc_d   = acc_q;

        // operand issued last cycle lands now; the bias slot is never an operand target
        for (int i = 0; i < NIN; i++) begin
            if (av_q && addr_q == AW'(i)) acc_d[i] = acc_q[i] + prod;
        end

        case (state_q)
            S_IDLE: begin
                if (i_clr) begin
                    for (int i = 0; i <= NIN; i++) acc_d[i] = '0;
                    count_d = '0;
                end else if (bus.i_valid) begin
                    d_d     = bus.i_dgate;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                av_d  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NIN - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                acc_d[NIN] = acc_q[NIN] + d_q;
                state_d    = S_DONE;
            end
            default: begin
                count_d = count_q + 16'd1;
                state_d = S_IDLE;
            end
        endcase

        grad_d = '0;
        for (int i = 0; i <= NIN; i++) begin
            if (i_rd_idx == AW'(i)) grad_d = acc_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            av_q    <= 1'b0;
            grad_q  <= '0;
            count_q <= '0;
            for (int i = 0; i <= NIN; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            av_q    <= av_d;
            grad_q  <= grad_d;
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.o_ready   = (state_q == S_IDLE);
    assign bus.o_rd_en   = (state_q == S_RUN);
    assign bus.o_rd_addr = (state_q == S_RUN) ? cnt_q : '0;
    assign o_done        = (state_q == S_DONE);
    assign o_grad        = grad_q;
    assign o_count       = count_q;
endmodule
